// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_arbiter
//  Purpose  : Round-robin arbiter and bus multiplexer letting up to four
//             AHB-lite style masters share one slave port. The address bus
//             is granted to one owner at a time. An owner is limited to
//             HOLD_LIMIT accepted transfers while another master is waiting.
//             Write data follows the data-phase owner, so a handover needs
//             no bubble cycle.
//  Ports    : hclk/hresetn        - clock, async active-low reset
//             m_hbusreq/m_hgrant  - per-master request / one-hot grant
//             m_htrans/m_hwrite/m_haddr/m_hwdata - packed per-master buses
//             m_hready/m_hrdata   - slave response broadcast to masters
//             hmaster             - index of the address-phase owner
//             s_*                 - slave-side bus
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int HOLD_LIMIT  = 4
) (
    input  logic                          hclk,
    input  logic                          hresetn,
    input  logic [NUM_MASTERS-1:0]        m_hbusreq,
    output logic [NUM_MASTERS-1:0]        m_hgrant,
    input  logic [2*NUM_MASTERS-1:0]      m_htrans,
    input  logic [NUM_MASTERS-1:0]        m_hwrite,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_haddr,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_hwdata,
    output logic                          m_hready,
    output logic [DATA_W-1:0]             m_hrdata,
    output logic [1:0]                    hmaster,
    output logic [1:0]                    s_htrans,
    output logic                          s_hwrite,
    output logic [ADDR_W-1:0]             s_haddr,
    output logic [DATA_W-1:0]             s_hwdata,
    input  logic                          s_hready,
    input  logic [DATA_W-1:0]             s_hrdata
);

    localparam logic [4:0] C_HOLD_LIMIT = 5'(HOLD_LIMIT);

    logic [1:0]             owner_q, owner_d;
    logic [1:0]             data_owner_q, data_owner_d;
    logic [3:0]             hold_cnt_q, hold_cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic [1:0]             w_htrans;
    logic                   w_own_req;
    logic                   w_other;
    logic                   w_accept;
    logic                   w_release;
    logic [4:0]             w_hold_sum;
    logic [1:0]             w_next_owner;

    // Address-phase mux (owner) and data-phase mux (data owner). Requests
    // from non-owners are collected here as well.
    always_comb begin
        w_htrans  = 2'b00;
        s_hwrite  = 1'b0;
        s_haddr   = '0;
        s_hwdata  = '0;
        w_own_req = 1'b0;
        w_other   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == 2'(i)) begin
                w_htrans  = m_htrans[2*i +: 2];
                s_hwrite  = m_hwrite[i];
                s_haddr   = m_haddr[ADDR_W*i +: ADDR_W];
                w_own_req = m_hbusreq[i];
            end else if (m_hbusreq[i]) begin
                w_other = 1'b1;
            end
            if (data_owner_q == 2'(i)) begin
                s_hwdata = m_hwdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Reset blocks the slave from seeing a transfer while masters are
    // still driving garbage.
    assign s_htrans = hresetn ? w_htrans : 2'b00;
    assign m_hready = s_hready;
    assign m_hrdata = s_hrdata;
    assign hmaster  = owner_q;
    assign m_hgrant = grant_q;

    // Round-robin search: scan from farthest to nearest distance so the
    // nearest requester after the owner is the last (winning) assignment.
    always_comb begin
        w_next_owner = owner_q;
        for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (m_hbusreq[i] && (((int'(owner_q) + k) % NUM_MASTERS) == i)) begin
                    w_next_owner = 2'(i);
                end
            end
        end
    end

    // Next-state logic. Everything holds while the slave stalls.
    always_comb begin
        w_accept     = s_hready && s_htrans[1];
        w_hold_sum   = {1'b0, hold_cnt_q} + {4'b0000, w_accept};
        w_release    = w_other && (!w_own_req || (w_hold_sum >= C_HOLD_LIMIT));
        owner_d      = owner_q;
        data_owner_d = data_owner_q;
        hold_cnt_d   = hold_cnt_q;
        if (s_hready) begin
            // A transfer accepted at this edge keeps the old owner for its
            // data phase even when ownership moves on.
            data_owner_d = owner_q;
            if (w_release) begin
                owner_d    = w_next_owner;
                hold_cnt_d = 4'd0;
            end else if (w_hold_sum >= C_HOLD_LIMIT) begin
                hold_cnt_d = C_HOLD_LIMIT[3:0];
            end else begin
                hold_cnt_d = w_hold_sum[3:0];
            end
        end
        grant_d = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_d == 2'(i)) begin
                grant_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            owner_q      <= 2'd0;
            data_owner_q <= 2'd0;
            hold_cnt_q   <= 4'd0;
            grant_q      <= NUM_MASTERS'(1);
        end else begin
            owner_q      <= owner_d;
            data_owner_q <= data_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            grant_q      <= grant_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_arbiter
//  Purpose  : Self-checking bench for ahb_arbiter: directed scenarios plus
//             randomized traffic compared against a behavioural model of the
//             arbitration rules and a small slave memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter;

    localparam int NM = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int HL = 4;

    logic              hclk;
    logic              hresetn;
    logic [NM-1:0]     m_hbusreq;
    logic [NM-1:0]     m_hgrant;
    logic [2*NM-1:0]   m_htrans;
    logic [NM-1:0]     m_hwrite;
    logic [AW*NM-1:0]  m_haddr;
    logic [DW*NM-1:0]  m_hwdata;
    logic              m_hready;
    logic [DW-1:0]     m_hrdata;
    logic [1:0]        hmaster;
    logic [1:0]        s_htrans;
    logic              s_hwrite;
    logic [AW-1:0]     s_haddr;
    logic [DW-1:0]     s_hwdata;
    logic              s_hready;
    logic [DW-1:0]     s_hrdata;

    ahb_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .HOLD_LIMIT  (HL)
    ) uut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .m_hbusreq (m_hbusreq),
        .m_hgrant  (m_hgrant),
        .m_htrans  (m_htrans),
        .m_hwrite  (m_hwrite),
        .m_haddr   (m_haddr),
        .m_hwdata  (m_hwdata),
        .m_hready  (m_hready),
        .m_hrdata  (m_hrdata),
        .hmaster   (hmaster),
        .s_htrans  (s_htrans),
        .s_hwrite  (s_hwrite),
        .s_haddr   (s_haddr),
        .s_hwdata  (s_hwdata),
        .s_hready  (s_hready),
        .s_hrdata  (s_hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: address owner, data-phase owner, transfers counted
    // for the current owner.
    int mo = 0;
    int md = 0;
    int mh = 0;

    // Slave memory fed from the DUT's slave-side bus.
    logic [DW-1:0] mem [256];
    logic          pend_wr   = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: check outputs at the falling edge, apply slave and
    // model updates for the coming rising edge, return just after it.
    task automatic step();
        bit acc;
        bit other;
        int nxt;
        @(negedge hclk);
        if (!hresetn) begin
            mo = 0; md = 0; mh = 0; pend_wr = 1'b0;
        end
        chk("grant",    64'(m_hgrant), 64'd1 << mo);
        chk("hmaster",  64'(hmaster),  64'(mo));
        chk("s_htrans", 64'(s_htrans), hresetn ? 64'(m_htrans[2*mo +: 2]) : 64'd0);
        chk("s_hwrite", 64'(s_hwrite), 64'(m_hwrite[mo]));
        chk("s_haddr",  64'(s_haddr),  64'(m_haddr[AW*mo +: AW]));
        chk("s_hwdata", 64'(s_hwdata), 64'(m_hwdata[DW*md +: DW]));
        chk("m_hready", 64'(m_hready), 64'(s_hready));
        chk("m_hrdata", 64'(m_hrdata), 64'(s_hrdata));
        if (hresetn && s_hready) begin
            if (pend_wr) mem[pend_addr] = s_hwdata;
            pend_wr   = s_htrans[1] & s_hwrite;
            pend_addr = s_haddr;

            acc   = m_htrans[2*mo+1];
            other = 1'b0;
            for (int i = 0; i < NM; i++)
                if (i != mo && m_hbusreq[i]) other = 1'b1;
            nxt = mo;
            if (other && (!m_hbusreq[mo] || (mh + int'(acc)) >= HL)) begin
                for (int k = 1; k < NM; k++) begin
                    if (m_hbusreq[(mo + k) % NM]) begin
                        nxt = (mo + k) % NM;
                        break;
                    end
                end
                mh = 0;
            end else begin
                mh = (mh + int'(acc) > HL) ? HL : mh + int'(acc);
            end
            md = mo;
            mo = nxt;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        hresetn = 1'b0;
        repeat (n) step();
        hresetn = 1'b1;
    endtask

    task automatic set_m(input int i, input logic req, input logic [1:0] tr,
                         input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_hbusreq[i]        = req;
        m_htrans[2*i +: 2]  = tr;
        m_hwrite[i]         = wr;
        m_haddr[AW*i +: AW] = a;
        m_hwdata[DW*i +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        hresetn   = 1'b0;
        m_hbusreq = '0;
        m_htrans  = '0;
        m_hwrite  = '0;
        m_haddr   = '0;
        m_hwdata  = '0;
        s_hready  = 1'b1;
        s_hrdata  = 32'hCAFE_0001;
        @(posedge hclk);
        #1;

        // Reset holds the slave bus idle even with master 0 driving NONSEQ.
        set_m(0, 1'b1, 2'b10, 1'b0, 8'h33, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_htrans", 64'(s_htrans), 64'd0);
            chk("rst_grant",  64'(m_hgrant), 64'd1);
            chk("rst_hmaster", 64'(hmaster), 64'd0);
        end
        hresetn = 1'b1;
        #1;
        chk("post_rst_htrans", 64'(s_htrans), 64'h2);
        step();

        // Grant from park onto master 1, then a write through it.
        do_reset(2);
        set_m(0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
        set_m(1, 1'b1, 2'b00, 1'b0, 8'h00, 32'h0);
        step();
        chk("park_grant",   64'(m_hgrant), 64'b010);
        chk("park_hmaster", 64'(hmaster),  64'd1);
        set_m(1, 1'b1, 2'b10, 1'b1, 8'h05, 32'h0);
        step();
        set_m(1, 1'b0, 2'b00, 1'b0, 8'h00, 32'h55);
        step();
        chk("mem5", 64'(mem[5]), 64'h55);

        // Hold limit with back-to-back writes; handover data steering.
        do_reset(2);
        set_m(0, 1'b1, 2'b10, 1'b1, 8'h10, 32'h1010);
        set_m(1, 1'b1, 2'b10, 1'b1, 8'h11, 32'h1111);
        for (int i = 0; i < 12; i++) begin
            chk("hold_seq", 64'(hmaster), (i >= 4 && i < 8) ? 64'd1 : 64'd0);
            step();
            if (i == 4) chk("mem10", 64'(mem[8'h10]), 64'h1010);
            if (i == 8) chk("mem11", 64'(mem[8'h11]), 64'h1111);
        end

        // Stall freezes arbitration; switch happens at first ready edge.
        do_reset(2);
        set_m(0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
        set_m(1, 1'b1, 2'b00, 1'b0, 8'h00, 32'h0);
        s_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_grant",   64'(m_hgrant), 64'b001);
            chk("stall_hmaster", 64'(hmaster),  64'd0);
        end
        s_hready = 1'b1;
        step();
        chk("unstall_hmaster", 64'(hmaster),  64'd1);
        chk("unstall_grant",   64'(m_hgrant), 64'b010);

        // Asynchronous reset during master 1's data phase.
        set_m(1, 1'b1, 2'b10, 1'b1, 8'h20, 32'h0);
        step();
        set_m(1, 1'b0, 2'b00, 1'b0, 8'h00, 32'h2020);
        #2;
        hresetn = 1'b0;
        #1;
        chk("arst_grant",   64'(m_hgrant), 64'b001);
        chk("arst_hmaster", 64'(hmaster),  64'd0);
        chk("arst_htrans",  64'(s_htrans), 64'd0);
        step();
        hresetn = 1'b1;
        step();
        step();
        chk("arst_park", 64'(hmaster), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++)
                set_m(i, ($urandom_range(0, 9) < 6), 2'($urandom), 1'($urandom),
                      8'($urandom), $urandom);
            s_hready = ($urandom_range(0, 3) != 0);
            s_hrdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
